// File: rtl/count_display_mux.sv
// count_display_mux
// Shows a 4-bit value (0-15) as two decimal digits on a 2-digit, common-anode,
// multiplexed seven-segment display. The digits are time-multiplexed:
// blank, units, blank, tens. The input is latched once per frame, on the
// tens -> blank edge, so a digit can never change in the middle of a frame.
// All outputs are registered, so no combinational path runs from count_in
// to a pin.
//
// Optional build macro: COUNT_DISPLAY_MUX_LZB_EN (leading-zero blanking).
// When it is defined, the tens digit stays dark for values below 10.
// State timing is the same either way.
module count_display_mux #(
   parameter int TIMER_W   = 16,
   parameter int DIG_CYC   = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] count_in,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       frame_tick
);

   // Elaboration-time guard: both phase lengths must fit in the timer.
   if (DIG_CYC < 1 || DIG_CYC >= (1 << TIMER_W)) begin : g_bad_dig_cyc
      $error("count_display_mux: DIG_CYC must satisfy 1 <= DIG_CYC < 2**TIMER_W");
   end
   if (BLANK_CYC < 1 || BLANK_CYC >= (1 << TIMER_W)) begin : g_bad_blank_cyc
      $error("count_display_mux: BLANK_CYC must satisfy 1 <= BLANK_CYC < 2**TIMER_W");
   end

   // Terminal timer values for each kind of phase.
   localparam logic [TIMER_W-1:0] DIG_LAST   = TIMER_W'(DIG_CYC - 1);
   localparam logic [TIMER_W-1:0] BLANK_LAST = TIMER_W'(BLANK_CYC - 1);

   // Segment constants (active-low, bit order g,f,e,d,c,b,a).
   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [1:0] AN_OFF   = 2'b11;
   localparam logic [1:0] AN_UNITS = 2'b10;
   localparam logic [1:0] AN_TENS  = 2'b01;

   typedef enum logic [1:0] {
      S_BLANK_U = 2'd0,
      S_UNITS   = 2'd1,
      S_BLANK_T = 2'd2,
      S_TENS    = 2'd3
   } state_t;

   state_t             state_reg, state_next;
   logic [TIMER_W-1:0] timer_reg, timer_next;
   logic [3:0]         value_reg, value_next;
   logic [6:0]         seg_reg,   seg_next;
   logic [1:0]         an_reg,    an_next;
   logic               tick_reg,  tick_next;

   logic               phase_done;
   logic               tens_digit;
   logic [3:0]         units_digit;

   // Decimal digit to active-low segment pattern. Codes above 9 never occur
   // on the digit paths, so they simply show dark.
   function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
      logic [6:0] p;
      case (digit)
         4'd0:    p = 7'h40;
         4'd1:    p = 7'h79;
         4'd2:    p = 7'h24;
         4'd3:    p = 7'h30;
         4'd4:    p = 7'h19;
         4'd5:    p = 7'h12;
         4'd6:    p = 7'h02;
         4'd7:    p = 7'h78;
         4'd8:    p = 7'h00;
         4'd9:    p = 7'h10;
         default: p = SEG_OFF;
      endcase
      return p;
   endfunction

   // Split the latched value into tens (0/1) and units (0-9). The 4-bit
   // subtract cannot wrap, because tens is set only when value_reg >= 10.
   always_comb begin
      tens_digit  = (value_reg >= 4'd10);
      units_digit = value_reg - (tens_digit ? 4'd10 : 4'd0);
   end

   // Next state, timer, capture and registered-output values.
   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg + 1'b1;
      value_next = value_reg;
      tick_next  = 1'b0;
      an_next    = AN_OFF;
      seg_next   = SEG_OFF;

      // A phase ends on its last timer count; blank and digit phases differ.
      if (state_reg == S_BLANK_U || state_reg == S_BLANK_T) begin
         phase_done = (timer_reg == BLANK_LAST);
      end else begin
         phase_done = (timer_reg == DIG_LAST);
      end

      if (phase_done) begin
         timer_next = '0;
         case (state_reg)
            S_BLANK_U: state_next = S_UNITS;
            S_UNITS:   state_next = S_BLANK_T;
            S_BLANK_T: state_next = S_TENS;
            default:   state_next = S_BLANK_U;
         endcase
         // The end of the tens digit marks the frame boundary. The input is
         // latched only here, so the new value first shows in the next frame.
         if (state_reg == S_TENS) begin
            value_next = count_in;
            tick_next  = 1'b1;
         end
      end

      // Outputs are decoded from the upcoming state so they change on the
      // same edge as the state register. value_reg is stable whenever a
      // digit state is entered, because it only changes on entry to
      // S_BLANK_U.
      case (state_next)
         S_UNITS: begin
            an_next  = AN_UNITS;
            seg_next = seg_pattern(units_digit);
         end
         S_TENS: begin
`ifdef COUNT_DISPLAY_MUX_LZB_EN
            if (tens_digit) begin
               an_next  = AN_TENS;
               seg_next = seg_pattern(4'd1);
            end else begin
               an_next  = AN_OFF;
               seg_next = SEG_OFF;
            end
`else
            an_next  = AN_TENS;
            seg_next = seg_pattern({3'b000, tens_digit});
`endif
         end
         default: begin
            an_next  = AN_OFF;
            seg_next = SEG_OFF;
         end
      endcase
   end

   // State, timer, latched value and output registers. Reset wins over
   // everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_BLANK_U;
         timer_reg <= '0;
         value_reg <= 4'd0;
         an_reg    <= AN_OFF;
         seg_reg   <= SEG_OFF;
         tick_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         value_reg <= value_next;
         an_reg    <= an_next;
         seg_reg   <= seg_next;
         tick_reg  <= tick_next;
      end
   end

   assign seg        = seg_reg;
   assign an         = an_reg;
   assign frame_tick = tick_reg;

endmodule

// File: tb/tb_count_display_mux.sv
// Bench for count_display_mux with short phases (DIG_CYC=4, BLANK_CYC=2).
// A cycle-level reference model works from the cycle index within the frame
// and the value captured at each frame boundary. Every clock is compared
// against it, alongside table vectors and hand-written corner sequences.
module tb_count_display_mux;

   localparam int TW = 4;
   localparam int DC = 4;
   localparam int BC = 2;
   localparam int F  = 2 * (BC + DC);

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] count_in;
   logic [6:0] seg;
   logic [1:0] an;
   logic       frame_tick;

   int tests = 0;
   int fails = 0;
   int t;               // index of the cycle currently visible on the outputs
   int disp;            // value the model expects on display this frame

   typedef struct {
      logic [3:0] cin;
      logic [6:0] exp_units;
      logic [6:0] exp_tens;
      logic [1:0] exp_tens_an;
   } vec_t;

   vec_t vecs[8];

   count_display_mux #(.TIMER_W(TW), .DIG_CYC(DC), .BLANK_CYC(BC)) dut (
      .clk        (clk),
      .rst        (rst),
      .count_in   (count_in),
      .seg        (seg),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, t, act, exp);
      end
   endtask

   // Compare the outputs against the model's view of the current cycle.
   task automatic check_cycle();
      int p;
      logic [1:0] ean;
      logic [6:0] eseg;
      logic       etick;
      p     = t % F;
      ean   = 2'b11;
      eseg  = 7'h7F;
      etick = (p == 0) && (t >= F);
      if (p >= BC && p < BC + DC) begin
         ean  = 2'b10;
         eseg = pat(disp % 10);
      end else if (p >= 2 * BC + DC) begin
`ifdef COUNT_DISPLAY_MUX_LZB_EN
         if (disp >= 10) begin
            ean  = 2'b01;
            eseg = pat(1);
         end
`else
         ean  = 2'b01;
         eseg = pat(disp / 10);
`endif
      end
      chk("an", 32'(an), 32'(ean));
      chk("seg", 32'(seg), 32'(eseg));
      chk("frame_tick", 32'(frame_tick), 32'(etick));
   endtask

   // Advance one rising edge, update the model, then check at the falling edge.
   task automatic step();
      @(posedge clk);
      if (rst) begin
         t    = 0;
         disp = 0;
      end else begin
         if (t % F == F - 1) disp = int'(count_in);
         t++;
      end
      @(negedge clk);
      check_cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (t != target && guard < 1000) begin
         step();
         guard++;
      end
      if (t != target) chk("run_to_bound", t, target);
   endtask

   initial begin
      vecs[0] = '{4'd7,  7'h78, 7'h40, 2'b01};
      vecs[1] = '{4'd13, 7'h30, 7'h79, 2'b01};
      vecs[2] = '{4'd15, 7'h12, 7'h79, 2'b01};
      vecs[3] = '{4'd0,  7'h40, 7'h40, 2'b01};
      vecs[4] = '{4'd9,  7'h10, 7'h40, 2'b01};
      vecs[5] = '{4'd10, 7'h40, 7'h79, 2'b01};
      vecs[6] = '{4'd5,  7'h12, 7'h40, 2'b01};
      vecs[7] = '{4'd12, 7'h24, 7'h79, 2'b01};
`ifdef COUNT_DISPLAY_MUX_LZB_EN
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].cin < 4'd10) begin
            vecs[i].exp_tens    = 7'h7F;
            vecs[i].exp_tens_an = 2'b11;
         end
      end
`endif

      // Reset held for three cycles with a non-zero input.
      rst      = 1'b1;
      count_in = 4'd9;
      t        = 0;
      disp     = 0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) step();
      $display("[TB] reset hold: an=%b seg=%h tick=%b", an, seg, frame_tick);

      // First frame after reset always shows 00; the second frame shows 7.
      rst      = 1'b0;
      count_in = 4'd7;
      check_cycle();
      for (int c = 1; c <= 23; c++) begin
         step();
         if (c == 3)  begin chk("f1_units_an", 32'(an), 32'(2'b10)); chk("f1_units_seg", 32'(seg), 32'h40); end
         if (c == 12) chk("f1_tick", 32'(frame_tick), 1);
         if (c == 13) chk("f1_tick_off", 32'(frame_tick), 0);
         if (c == 15) chk("f2_units_seg", 32'(seg), 32'h78);
      end
      $display("[TB] first frames with count_in=7 done at cycle %0d", t);

      // Table vectors: the value shows in the second frame after reset.
      for (int i = 0; i < 8; i++) begin
         do_reset();
         count_in = vecs[i].cin;
         run_to(F + BC);
         chk("vec_units_an", 32'(an), 32'(2'b10));
         chk("vec_units_seg", 32'(seg), 32'(vecs[i].exp_units));
         run_to(F + 2 * BC + DC + 1);
         chk("vec_tens_an", 32'(an), 32'(vecs[i].exp_tens_an));
         chk("vec_tens_seg", 32'(seg), 32'(vecs[i].exp_tens));
         $display("[TB] vector count_in=%0d units=%h tens=%h an=%b", vecs[i].cin, vecs[i].exp_units, seg, an);
      end

      // Mid-frame input change must wait for the next frame boundary.
      do_reset();
      count_in = 4'd3;
      run_to(15);
      count_in = 4'd8;
      chk("mid_f2_units", 32'(seg), 32'h30);
      run_to(20); chk("mid_f2_tens", 32'(seg), 32'((`ifdef COUNT_DISPLAY_MUX_LZB_EN 7'h7F `else 7'h40 `endif)));
      run_to(24); chk("mid_tick24", 32'(frame_tick), 1);
      run_to(26); chk("mid_f3_units", 32'(seg), 32'h00);
      run_to(36); chk("mid_tick36", 32'(frame_tick), 1);
      $display("[TB] mid-frame change 3->8 checked through cycle %0d", t);

      // Reset asserted in the middle of the tens digit.
      do_reset();
      count_in = 4'd11;
      run_to(9);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_an", 32'(an), 32'(2'b11));
      chk("midrst_seg", 32'(seg), 32'h7F);
      run_to(2);  chk("midrst_units", 32'(seg), 32'h40);
      run_to(12); chk("midrst_tick", 32'(frame_tick), 1);
      run_to(F + BC); chk("midrst_f2_units", 32'(seg), 32'h79);
      $display("[TB] reset mid-digit recovered, cycle %0d", t);

      // Random input changes and occasional resets against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 4) == 0) count_in = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 299) == 0);
         step();
         if (c % (F * 25) == F * 25 - 1)
            $display("[TB] random burst at step %0d: count_in=%0d disp=%0d", c, count_in, disp);
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
